// File: rtl/swb_activation_sequencer.sv
// Per-port activation pulse sequencer feeding the switchbox activate input.
// REP/REPX set per-port repeat configs; a trigger emits iter+1 spaced pulses.
module swb_activation_sequencer #(
  parameter int FSM_PER_SLOT         = 4,
  parameter int RESOURCE_INSTR_WIDTH = 27,
  parameter int CNT_WIDTH            = 12
) (
  input  logic                            clk_0,
  input  logic                            rst_0,
  input  logic                            instr_en_0,
  input  logic [RESOURCE_INSTR_WIDTH-1:0] instr_0,
  input  logic [FSM_PER_SLOT-1:0]         trigger_i,
  output logic [FSM_PER_SLOT-1:0]         activate_o,
  output logic [FSM_PER_SLOT-1:0]         busy_o,
  output logic [FSM_PER_SLOT-1:0]         overrun_o
);

  localparam logic [2:0] OPCODE_REP  = 3'b000;
  localparam logic [2:0] OPCODE_REPX = 3'b001;

  typedef struct packed {
    logic [1:0] port;
    logic [3:0] level;
    logic [5:0] iter;
    logic [5:0] step;
    logic [5:0] delay;
  } rep_t;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  logic [2:0] opcode;
  rep_t       rep;
  logic       rep_hit;
  logic       repx_hit;
  logic       unused_step;

  assign opcode      = instr_0[26:24];
  assign rep         = rep_t'(instr_0[23:0]);
  assign unused_step = ^rep.step;

  // Only level-0 instructions address this resource's sequencers.
  assign rep_hit  = instr_en_0 && (opcode == OPCODE_REP)
                    && (rep.level == 4'd0);
  assign repx_hit = instr_en_0 && (opcode == OPCODE_REPX)
                    && (rep.level == 4'd0);

  for (genvar p = 0; p < FSM_PER_SLOT; p++) begin : g_port
    logic [CNT_WIDTH-1:0] cfg_iter;
    logic [CNT_WIDTH-1:0] cfg_delay;
    logic [CNT_WIDTH-1:0] rep_cnt;
    logic [CNT_WIDTH-1:0] dly_cnt;
    logic [CNT_WIDTH-1:0] dly_rld;
    state_t               state;
    logic                 act_q;
    logic                 ovr_q;
    logic                 sel;

    assign sel           = (32'(rep.port) == p);
    assign activate_o[p] = act_q;
    assign overrun_o[p]  = ovr_q;
    assign busy_o[p]     = (state == WAIT);

    // Config write: REP fills the low half, REPX the high half.
    always_ff @(posedge clk_0 or posedge rst_0) begin
      if (rst_0) begin
        cfg_iter  <= '0;
        cfg_delay <= '0;
      end else if (sel && rep_hit) begin
        cfg_iter[5:0]  <= rep.iter;
        cfg_delay[5:0] <= rep.delay;
      end else if (sel && repx_hit) begin
        cfg_iter[11:6]  <= rep.iter;
        cfg_delay[11:6] <= rep.delay;
      end
    end

    // Sequencer: snapshot config on trigger, then count delays and repeats.
    always_ff @(posedge clk_0 or posedge rst_0) begin
      if (rst_0) begin
        state   <= IDLE;
        rep_cnt <= '0;
        dly_cnt <= '0;
        dly_rld <= '0;
        act_q   <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        act_q <= 1'b0;
        unique case (state)
          IDLE: begin
            if (trigger_i[p]) begin
              act_q   <= 1'b1;
              rep_cnt <= cfg_iter;
              dly_cnt <= cfg_delay;
              dly_rld <= cfg_delay;
              if (cfg_iter != '0)
                state <= WAIT;
            end
          end
          WAIT: begin
            if (trigger_i[p])
              ovr_q <= 1'b1;
            if (rep_cnt == '0) begin
              state <= IDLE;
            end else if (dly_cnt != '0) begin
              dly_cnt <= dly_cnt - CNT_WIDTH'(1);
            end else begin
              act_q   <= 1'b1;
              rep_cnt <= rep_cnt - CNT_WIDTH'(1);
              dly_cnt <= dly_rld;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swb_activation_sequencer.sv
// Scoreboard bench for swb_activation_sequencer.
// Stimulus pushes expected pulse cycles; a negedge monitor pops and checks.
module tb_swb_activation_sequencer;

  logic        clk_0 = 1'b0;
  logic        rst_0;
  logic        instr_en_0;
  logic [26:0] instr_0;
  logic [3:0]  trigger_i;
  logic [3:0]  activate_o;
  logic [3:0]  busy_o;
  logic [3:0]  overrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c;
  int expq [4][$];

  swb_activation_sequencer dut (
    .clk_0      (clk_0),
    .rst_0      (rst_0),
    .instr_en_0 (instr_en_0),
    .instr_0    (instr_0),
    .trigger_i  (trigger_i),
    .activate_o (activate_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_0 = ~clk_0;

  always @(posedge clk_0) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected cycle of its port.
  always @(negedge clk_0) begin
    if (!rst_0) begin
      for (int p = 0; p < 4; p++) begin
        while (expq[p].size() > 0 && expq[p][0] < cyc) begin
          chk($sformatf("missed_pulse_p%0d", p), cyc, expq[p][0]);
          void'(expq[p].pop_front());
        end
        if (activate_o[p]) begin
          if (expq[p].size() == 0) begin
            chk($sformatf("unexpected_pulse_p%0d", p), cyc, -1);
          end else begin
            chk($sformatf("pulse_cycle_p%0d", p), cyc, expq[p][0]);
            void'(expq[p].pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] port,
                      input logic [3:0] lvl, input logic [5:0] it,
                      input logic [5:0] dl);
    instr_en_0 = 1'b1;
    instr_0    = {op, port, lvl, it, 6'd0, dl};
    @(negedge clk_0);
    instr_en_0 = 1'b0;
    instr_0    = '0;
  endtask

  // Trigger port p; expect n pulses, sp cycles apart, from the next edge.
  task automatic trig(input int p, input int n, input int sp);
    int base;
    base = cyc + 1;
    for (int k = 0; k < n; k++) expq[p].push_back(base + k * sp);
    trigger_i[p] = 1'b1;
    @(negedge clk_0);
    trigger_i[p] = 1'b0;
  endtask

  task automatic poke(input int p);
    trigger_i[p] = 1'b1;
    @(negedge clk_0);
    trigger_i[p] = 1'b0;
  endtask

  task automatic count_busy(input int p, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      if (busy_o[p]) cnt++;
      @(negedge clk_0);
    end
  endtask

  initial begin
    rst_0      = 1'b1;
    instr_en_0 = 1'b0;
    instr_0    = '0;
    trigger_i  = '0;
    repeat (2) @(negedge clk_0);
    chk("reset_activate", int'(activate_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_overrun", int'(overrun_o), 0);
    rst_0 = 1'b0;
    @(negedge clk_0);

    // Non-zero level and unknown opcode must leave port0 at iter=0.
    send(3'b000, 2'd0, 4'd1, 6'd5, 6'd0);
    send(3'b010, 2'd0, 4'd0, 6'd5, 6'd0);

    // Unconfigured port0: single pulse, never busy.
    trig(0, 1, 1);
    chk("p0_single_busy", int'(busy_o[0]), 0);
    repeat (5) @(negedge clk_0);

    // Port1 iter=3 delay=2: four pulses three cycles apart.
    send(3'b000, 2'd1, 4'd0, 6'd3, 6'd2);
    trig(1, 4, 3);
    count_busy(1, 15, c);
    chk("p1_busy_cycles", c, 10);
    chk("p1_overrun", int'(overrun_o), 0);

    // Port2 iter=64 via REPX high half: 65 back-to-back pulses.
    send(3'b001, 2'd2, 4'd0, 6'd1, 6'd0);
    send(3'b000, 2'd2, 4'd0, 6'd0, 6'd0);
    trig(2, 65, 1);
    count_busy(2, 70, c);
    chk("p2_busy_cycles", c, 65);
    chk("p2_idle_after", int'(busy_o[2]), 0);

    // Port3 iter=2 delay=5 with a retrigger mid-sequence.
    send(3'b000, 2'd3, 4'd0, 6'd2, 6'd5);
    trig(3, 3, 6);
    repeat (2) @(negedge clk_0);
    poke(3);
    chk("p3_overrun_set", int'(overrun_o), 8);
    repeat (15) @(negedge clk_0);
    chk("p3_overrun_held", int'(overrun_o), 8);
    chk("p3_idle_after", int'(busy_o[3]), 0);

    // Same-cycle config and trigger on port0: old config (one pulse).
    expq[0].push_back(cyc + 1);
    instr_en_0   = 1'b1;
    instr_0      = {3'b000, 2'd0, 4'd0, 6'd1, 6'd0, 6'd0};
    trigger_i[0] = 1'b1;
    @(negedge clk_0);
    instr_en_0   = 1'b0;
    instr_0      = '0;
    trigger_i[0] = 1'b0;
    chk("p0_same_cycle_busy", int'(busy_o[0]), 0);
    repeat (3) @(negedge clk_0);
    trig(0, 2, 1);
    chk("p0_new_cfg_busy", int'(busy_o[0]), 1);
    repeat (4) @(negedge clk_0);

    // Reset during port1 sequence after its second pulse.
    trig(1, 2, 3);
    repeat (4) @(negedge clk_0);
    #2 rst_0 = 1'b1;
    #1;
    chk("midrst_activate", int'(activate_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_overrun", int'(overrun_o), 0);
    repeat (3) @(negedge clk_0);
    rst_0 = 1'b0;
    repeat (20) @(negedge clk_0);
    trig(1, 1, 1);
    chk("p1_cfg_cleared_busy", int'(busy_o[1]), 0);
    repeat (5) @(negedge clk_0);

    for (int p = 0; p < 4; p++)
      chk($sformatf("leftover_p%0d", p), expq[p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
